// File: rtl/ram_sp_ctrl_pkg.sv
// Shared definitions for the single-port data memory controller:
// FSM state encoding and read/write direction constants.
package mem_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage : mem_pkg

// File: rtl/ram_sp_ctrl_if.sv
// Request/response bus between the control unit (master) and the
// data memory controller (slave).
interface ram_sp_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) ();

    logic              req_valid;
    logic              req_ready;
    logic              read_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rsp_valid;
    logic              err;

    modport master (
        output req_valid, read_write, addr, data_in,
        input  req_ready, data_out, rsp_valid, err
    );

    modport slave (
        input  req_valid, read_write, addr, data_in,
        output req_ready, data_out, rsp_valid, err
    );

endinterface : ram_sp_ctrl_if

// File: rtl/ram_sp_core.sv
// Storage array for the data memory: one shared address port with a
// synchronous write enable and a registered synchronous read. A read
// can be forced to return zero (used for out-of-range addresses).
module ram_sp_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic              rzero,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read data; holds its value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (re) begin
            if (rzero) begin
                rdata_r <= '0;
            end else begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule : ram_sp_core

// File: rtl/ram_sp_ctrl.sv
// Single-port data memory controller: valid/ready request handshake,
// one-cycle response strobe, address range check and a clear sequencer
// that walks the whole array writing CLEAR_VAL.
module ram_sp_ctrl
    import mem_pkg::*;
#(
    parameter int                DATA_W         = 8,
    parameter int                ADDR_W         = 5,
    parameter int                DEPTH          = 32,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_sp_ctrl_if.slave        bus,
    input  logic                clear,
    output logic                busy
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam state_t            RESET_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_s;

    logic              req_ready_s;
    logic              accept_s;
    logic              in_range_s;

    logic              mem_we_s;
    logic              mem_re_s;
    logic              mem_rzero_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] mem_rdata_s;

    logic              rsp_valid_r;
    logic              err_r;

    assign req_ready_s = (state_r == ST_IDLE) && !clear;
    assign accept_s    = bus.req_valid && req_ready_s;
    assign in_range_s  = ({1'b0, bus.addr} < DEPTH_C);

    // FSM state and clear pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RESET_ST;
            ptr_r   <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
        end
    end

    // Next-state logic; the pointer stops at DEPTH-1 and never wraps.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    state_s = ST_CLEAR;
                    ptr_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (ptr_r == LAST_PTR) begin
                    state_s = ST_IDLE;
                    ptr_s   = '0;
                end else begin
                    ptr_s   = ptr_r + ADDR_W'(1);
                end
            end
            default: begin
                state_s = RESET_ST;
                ptr_s   = '0;
            end
        endcase
    end

    // Memory port steering: the clear sequencer owns the port while busy.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_rzero_s = 1'b0;
        mem_addr_s  = bus.addr;
        mem_wdata_s = bus.data_in;
        if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = ptr_r;
            mem_wdata_s = CLEAR_VAL;
        end else begin
            mem_we_s    = accept_s && (bus.read_write == RW_WRITE) && in_range_s;
            mem_re_s    = accept_s && (bus.read_write == RW_READ);
            mem_rzero_s = !in_range_s;
        end
    end

    // Response strobe and error flag; err holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            rsp_valid_r <= accept_s;
            if (accept_s) begin
                err_r <= !in_range_s;
            end
        end
    end

    ram_sp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .rzero (mem_rzero_s),
        .addr  (mem_addr_s),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

    assign bus.req_ready = req_ready_s;
    assign bus.data_out  = mem_rdata_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.err       = err_r;
    assign busy          = (state_r == ST_CLEAR);

endmodule : ram_sp_ctrl

// File: tb/tb_ram_sp_ctrl.sv
// Bench for ram_sp_ctrl: a default 32-word instance and a 24-word
// instance, driven by per-scenario tasks. Expected responses are queued
// when a request is issued and compared when rsp_valid appears.
module tb_ram_sp_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clear0;
    logic clear1;
    logic busy0;
    logic busy1;

    int n_tests;
    int n_fail;

    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] model [2][32];
    logic [7:0] last_data [2];

    ram_sp_ctrl_if #(.DATA_W(8), .ADDR_W(5)) if0 ();
    ram_sp_ctrl_if #(.DATA_W(8), .ADDR_W(5)) if1 ();

    ram_sp_ctrl #(
        .DATA_W(8), .ADDR_W(5), .DEPTH(32), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(if0), .clear(clear0), .busy(busy0)
    );

    ram_sp_ctrl #(
        .DATA_W(8), .ADDR_W(5), .DEPTH(24), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(8'h00)
    ) dut24 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .clear(clear1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard for the 32-word instance.
    always @(negedge clk) begin
        if (rst_n && if0.rsp_valid) begin
            exp_t e;
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp0 got rsp_valid=1 want no response");
            end else begin
                e = q0.pop_front();
                n_tests++;
                if (if0.data_out !== e.data) begin
                    n_fail++;
                    $display("FAIL rsp0_data got %02h want %02h", if0.data_out, e.data);
                end
                n_tests++;
                if (if0.err !== e.err) begin
                    n_fail++;
                    $display("FAIL rsp0_err got %b want %b", if0.err, e.err);
                end
            end
        end
    end

    // Scoreboard for the 24-word instance.
    always @(negedge clk) begin
        if (rst_n && if1.rsp_valid) begin
            exp_t e;
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp1 got rsp_valid=1 want no response");
            end else begin
                e = q1.pop_front();
                n_tests++;
                if (if1.data_out !== e.data) begin
                    n_fail++;
                    $display("FAIL rsp1_data got %02h want %02h", if1.data_out, e.data);
                end
                n_tests++;
                if (if1.err !== e.err) begin
                    n_fail++;
                    $display("FAIL rsp1_err got %b want %b", if1.err, e.err);
                end
            end
        end
    end

    task automatic model_zero();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 32; i++) model[s][i] = 8'h00;
        end
    endtask

    // Presents one request for one cycle (called 1 time unit after a rising edge).
    task automatic issue(input int sel, input logic rw, input logic [4:0] a, input logic [7:0] d);
        exp_t e;
        logic in_r;
        logic rdy;
        in_r = (sel == 0) ? 1'b1 : (a < 5'd24);
        if (sel == 0) begin
            if0.req_valid = 1'b1; if0.read_write = rw; if0.addr = a; if0.data_in = d;
            #0 rdy = if0.req_ready;
        end else begin
            if1.req_valid = 1'b1; if1.read_write = rw; if1.addr = a; if1.data_in = d;
            #0 rdy = if1.req_ready;
        end
        n_tests++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready%0d got %b want 1", sel, rdy);
        end
        if (rw) begin
            if (in_r) model[sel][a] = d;
            e.data = last_data[sel];
        end else begin
            e.data = in_r ? model[sel][a] : 8'h00;
            last_data[sel] = e.data;
        end
        e.err = !in_r;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        if0.req_valid = 1'b0;
        if1.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained();
        idle(3);
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drained got pending %0d/%0d want 0/0", q0.size(), q1.size());
        end
    endtask

    // Counts busy cycles on both instances over a bounded window.
    task automatic count_busy(input int want0, input int want1);
        int c0;
        int c1;
        int bad;
        c0 = 0; c1 = 0; bad = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (busy0) c0++;
            if (busy1) c1++;
            if ((busy0 && if0.req_ready) || (busy1 && if1.req_ready)) bad++;
        end
        n_tests++;
        if (c0 != want0) begin
            n_fail++;
            $display("FAIL busy_cycles0 got %0d want %0d", c0, want0);
        end
        n_tests++;
        if (c1 != want1) begin
            n_fail++;
            $display("FAIL busy_cycles1 got %0d want %0d", c1, want1);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ready_while_busy got %0d cycles want 0", bad);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear0 = 1'b0; clear1 = 1'b0;
        if0.req_valid = 1'b0; if0.read_write = 1'b0; if0.addr = 5'd0; if0.data_in = 8'h00;
        if1.req_valid = 1'b0; if1.read_write = 1'b0; if1.addr = 5'd0; if1.data_in = 8'h00;
        model_zero();
        last_data[0] = 8'h00; last_data[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (if0.rsp_valid !== 1'b0 || if0.data_out !== 8'h00 || if0.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got rsp=%b data=%02h err=%b want 0/00/0",
                     if0.rsp_valid, if0.data_out, if0.err);
        end
        n_tests++;
        if (busy0 !== 1'b1 || if0.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got busy=%b ready=%b want 1/0", busy0, if0.req_ready);
        end
        rst_n = 1'b1;
        count_busy(32, 24);
        issue(0, 1'b0, 5'd7, 8'h00);
        check_drained();
    endtask

    task automatic test_write_read();
        issue(0, 1'b1, 5'd3, 8'hA5);
        issue(0, 1'b0, 5'd3, 8'h00);
        check_drained();
    endtask

    task automatic test_back_to_back();
        issue(0, 1'b1, 5'd31, 8'h5A);
        issue(0, 1'b0, 5'd31, 8'h00);
        issue(0, 1'b1, 5'd0,  8'h11);
        issue(0, 1'b0, 5'd0,  8'h00);
        check_drained();
    endtask

    task automatic test_out_of_range();
        issue(1, 1'b1, 5'd25, 8'hFF);
        issue(1, 1'b0, 5'd25, 8'h00);
        issue(1, 1'b1, 5'd23, 8'h3C);
        issue(1, 1'b0, 5'd23, 8'h00);
        issue(1, 1'b0, 5'd24, 8'h00);
        check_drained();
    endtask

    task automatic test_clear();
        for (int a = 0; a < 32; a++) begin
            issue(0, 1'b1, 5'(a), 8'(a + 1));
        end
        issue(0, 1'b0, 5'd10, 8'h00);
        check_drained();
        clear0 = 1'b1;
        if0.req_valid = 1'b1; if0.read_write = 1'b1; if0.addr = 5'd10; if0.data_in = 8'hEE;
        #0;
        n_tests++;
        if (if0.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_blocks_req got ready=%b want 0", if0.req_ready);
        end
        @(posedge clk);
        #1;
        clear0 = 1'b0;
        if0.req_valid = 1'b0;
        model_zero();
        count_busy(32, 0);
        issue(0, 1'b0, 5'd10, 8'h00);
        issue(0, 1'b0, 5'd31, 8'h00);
        check_drained();
    endtask

    task automatic test_reset_mid_clear();
        issue(0, 1'b1, 5'd4, 8'h66);
        issue(0, 1'b0, 5'd4, 8'h00);
        check_drained();
        clear0 = 1'b1;
        @(posedge clk);
        #1;
        clear0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (busy0 !== 1'b1 || if0.data_out !== 8'h66) begin
            n_fail++;
            $display("FAIL mid_clear got busy=%b data=%02h want 1/66", busy0, if0.data_out);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (if0.rsp_valid !== 1'b0 || if0.data_out !== 8'h00 || if0.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_clear got rsp=%b data=%02h ready=%b want 0/00/0",
                     if0.rsp_valid, if0.data_out, if0.req_ready);
        end
        model_zero();
        last_data[0] = 8'h00; last_data[1] = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_busy(32, 24);
        issue(0, 1'b0, 5'd4, 8'h00);
        issue(0, 1'b0, 5'd20, 8'h00);
        check_drained();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_clear();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_sp_ctrl
